// File: rtl/frame_timing_checker.sv
// Receive-side checker for the three-signal half-cycle frame protocol.
// Samples on both clock edges and reports per-cycle and per-frame window mismatches.
module frame_timing_checker #(
  parameter int S1_FALL = 6,
  parameter int S1_RISE = 9,
  parameter int S2_FALL = 7,
  parameter int S2_RISE = 8,
  parameter int S3_FALL = 4,
  parameter int S3_RISE = 11,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig1,
  input  logic             sig2,
  input  logic             sig3,
  output logic             err,
  output logic [2:0]       err_mask,
  output logic [3:0]       err_slot,
  output logic             frame_done,
  output logic             frame_ok,
  output logic [CNT_W-1:0] good_frames,
  output logic             err_sticky
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Expected level of one signal in half-slot h: low inside [fall, rise).
  function automatic logic exp_level(input logic [3:0] h, input int fall, input int rise);
    int hi;
    hi = {28'd0, h};
    return ((hi >= fall) && (hi < rise)) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic [2:0] exp_vec(input logic [3:0] h);
    return {exp_level(h, S3_FALL, S3_RISE),
            exp_level(h, S2_FALL, S2_RISE),
            exp_level(h, S1_FALL, S1_RISE)};
  endfunction

  logic [2:0]       neg_r;
  logic             run_r;
  logic [2:0]       fc_r;
  logic             acc_r;
  logic             err_r;
  logic [2:0]       mask_r;
  logic [3:0]       slot_r;
  logic             fd_r;
  logic             fok_r;
  logic [CNT_W-1:0] gf_r;
  logic             sticky_r;

  logic [3:0] even_h_s;
  logic [3:0] odd_h_s;
  logic [2:0] mis_even_s;
  logic [2:0] mis_odd_s;
  logic [2:0] mask_s;
  logic       any_s;
  logic [3:0] slot_s;
  logic       frame_bad_s;

  // Capture the even half-slot at the falling edge that ends it.
  always_ff @(negedge clk) begin
    if (rst) begin
      neg_r <= 3'b111;
    end else begin
      neg_r <= {sig3, sig2, sig1};
    end
  end

  // Compare both half-slots of the current cycle against their windows.
  always_comb begin
    even_h_s    = {fc_r, 1'b0};
    odd_h_s     = {fc_r, 1'b1};
    mis_even_s  = neg_r ^ exp_vec(even_h_s);
    mis_odd_s   = {sig3, sig2, sig1} ^ exp_vec(odd_h_s);
    mask_s      = mis_even_s | mis_odd_s;
    any_s       = |mask_s;
    frame_bad_s = acc_r | any_s;
    if (|mis_even_s) begin
      slot_s = even_h_s;
    end else if (any_s) begin
      slot_s = odd_h_s;
    end else begin
      slot_s = 4'd0;
    end
  end

  // Frame position tracking and registered reporting.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_r    <= 1'b0;
      fc_r     <= 3'd0;
      acc_r    <= 1'b0;
      err_r    <= 1'b0;
      mask_r   <= 3'd0;
      slot_r   <= 4'd0;
      fd_r     <= 1'b0;
      fok_r    <= 1'b0;
      gf_r     <= {CNT_W{1'b0}};
      sticky_r <= 1'b0;
    end else if (!run_r) begin
      run_r  <= 1'b1;
      fc_r   <= 3'd0;
      acc_r  <= 1'b0;
      err_r  <= 1'b0;
      mask_r <= 3'd0;
      slot_r <= 4'd0;
      fd_r   <= 1'b0;
      fok_r  <= 1'b0;
    end else begin
      fc_r     <= fc_r + 3'd1;
      err_r    <= any_s;
      mask_r   <= mask_s;
      slot_r   <= slot_s;
      sticky_r <= sticky_r | any_s;
      if (fc_r == 3'd7) begin
        fd_r  <= 1'b1;
        fok_r <= ~frame_bad_s;
        acc_r <= 1'b0;
        if (!frame_bad_s && (gf_r != CNT_MAX)) begin
          gf_r <= gf_r + CNT_ONE;
        end
      end else begin
        fd_r  <= 1'b0;
        fok_r <= 1'b0;
        acc_r <= frame_bad_s;
      end
    end
  end

  assign err         = err_r;
  assign err_mask    = mask_r;
  assign err_slot    = slot_r;
  assign frame_done  = fd_r;
  assign frame_ok    = fok_r;
  assign good_frames = gf_r;
  assign err_sticky  = sticky_r;

endmodule
